// File: rtl/key_beep_pkg.sv
// Shared state type, 50 MHz default timing and the per-key tone helper
// for the multi-key debounce/beep block.
package key_beep_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        TONE = 1'b1
    } state_e;

    localparam int unsigned CNT_MAX_DEFAULT   = 32'd999_999;
    localparam int unsigned BEEP_CNT_DEFAULT  = 32'd25_000_000;
    localparam int unsigned TONE_BASE_DEFAULT = 32'd50_000;
    localparam int unsigned TONE_STEP_DEFAULT = 32'd5_000;

    function automatic int unsigned half_period(
        input int unsigned idx,
        input int unsigned base,
        input int unsigned step
    );
        return base + idx * step;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One active-low key: 2-FF synchroniser, debounce counter, debounced level
// (1 = pressed) and a single-cycle pulse on each debounced press.
module key_debounce #(
    parameter int unsigned CNT_MAX = 32'd999_999
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic key_state_o,
    output logic key_press_o
);

    logic        sync1_q;
    logic        sync2_q;
    logic        state_q;
    logic        state_d;
    logic        press_q;
    logic        press_d;
    logic [19:0] cnt_q;
    logic [19:0] cnt_d;
    logic        s_s;

    assign s_s = ~sync2_q;

    // Synchroniser stages start at the released level so reset never looks like a press
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= 20'd0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any bounce back to the current level restarts the stability window
    always_comb begin
        state_d = state_q;
        press_d = 1'b0;
        cnt_d   = cnt_q;
        if (s_s == state_q) begin
            cnt_d = 20'd0;
        end else if (cnt_q == 20'(CNT_MAX)) begin
            state_d = s_s;
            press_d = s_s;
            cnt_d   = 20'd0;
        end else begin
            cnt_d = cnt_q + 20'd1;
        end
    end

    assign key_state_o = state_q;
    assign key_press_o = press_q;

endmodule

// File: rtl/key_beep_multi.sv
// Multi-key debouncer with a per-key-pitch tone burst on the buzzer.
// Optional `BEEP_HOLD_EN: the burst is extended while the selected key stays pressed.
module key_beep_multi
    import key_beep_pkg::*;
#(
    parameter int unsigned KEY_NUM   = 32'd4,
    parameter int unsigned CNT_MAX   = CNT_MAX_DEFAULT,
    parameter int unsigned BEEP_CNT  = BEEP_CNT_DEFAULT,
    parameter int unsigned TONE_BASE = TONE_BASE_DEFAULT,
    parameter int unsigned TONE_STEP = TONE_STEP_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KEY_NUM-1:0] key,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] key_press,
    output logic               beep,
    output logic               busy
);

    localparam int unsigned HP_MAX = TONE_BASE + (KEY_NUM - 32'd1) * TONE_STEP;
    localparam int unsigned HP_W   = $clog2(HP_MAX + 32'd1);
    localparam int unsigned DUR_W  = $clog2(BEEP_CNT + 32'd1);
    localparam int unsigned SEL_W  = (KEY_NUM > 32'd1) ? $clog2(KEY_NUM) : 32'd1;

    state_e             state_q;
    state_e             state_d;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   sel_d;
    logic [DUR_W-1:0]   dur_q;
    logic [DUR_W-1:0]   dur_d;
    logic [HP_W-1:0]    half_q;
    logic [HP_W-1:0]    half_d;
    logic               beep_q;
    logic               beep_d;
    logic [HP_W-1:0]    hp_s;
    logic               any_press_s;
    logic               dur_end_s;
    logic               half_end_s;
    logic               hold_s;

    for (genvar gi = 0; gi < int'(KEY_NUM); gi++) begin : g_key
        key_debounce #(
            .CNT_MAX (CNT_MAX)
        ) u_debounce (
            .clk         (clk),
            .rst_n       (rst_n),
            .key_i       (key[gi]),
            .key_state_o (key_state[gi]),
            .key_press_o (key_press[gi])
        );
    end

    function automatic logic [SEL_W-1:0] lowest_set(input logic [KEY_NUM-1:0] v);
        logic [SEL_W-1:0] idx;
        idx = {SEL_W{1'b0}};
        for (int i = int'(KEY_NUM) - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = SEL_W'(i);
            end
        end
        return idx;
    endfunction

    assign any_press_s = |key_press;
    assign hp_s        = HP_W'(half_period(32'(sel_q), TONE_BASE, TONE_STEP));
    assign dur_end_s   = (dur_q == DUR_W'(BEEP_CNT - 32'd1));
    assign half_end_s  = (half_q == (hp_s - HP_W'(1)));

`ifdef BEEP_HOLD_EN
    assign hold_s = key_state[sel_q];
`else
    assign hold_s = 1'b0;
`endif

    // State and burst datapath registers; reset silences the buzzer at once
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= {SEL_W{1'b0}};
            dur_q   <= {DUR_W{1'b0}};
            half_q  <= {HP_W{1'b0}};
            beep_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            dur_q   <= dur_d;
            half_q  <= half_d;
            beep_q  <= beep_d;
        end
    end

    // Next state: a new press always (re)starts a burst, even on its last cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_press_s) state_d = TONE;
                else             state_d = IDLE;
            end
            TONE: begin
                if (any_press_s)                 state_d = TONE;
                else if (dur_end_s && !hold_s)   state_d = IDLE;
                else                             state_d = TONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Burst outputs: the tone keeps running while a held burst parks dur_q at its end
    always_comb begin
        sel_d  = sel_q;
        dur_d  = dur_q;
        half_d = half_q;
        beep_d = beep_q;
        if (any_press_s) begin
            sel_d  = lowest_set(key_press);
            dur_d  = {DUR_W{1'b0}};
            half_d = {HP_W{1'b0}};
            beep_d = 1'b1;
        end else if (state_q == TONE) begin
            if (dur_end_s && !hold_s) begin
                dur_d  = {DUR_W{1'b0}};
                half_d = {HP_W{1'b0}};
                beep_d = 1'b0;
            end else begin
                if (dur_end_s) dur_d = dur_q;
                else           dur_d = dur_q + DUR_W'(1);
                if (half_end_s) begin
                    half_d = {HP_W{1'b0}};
                    beep_d = ~beep_q;
                end else begin
                    half_d = half_q + HP_W'(1);
                    beep_d = beep_q;
                end
            end
        end else begin
            dur_d  = {DUR_W{1'b0}};
            half_d = {HP_W{1'b0}};
            beep_d = 1'b0;
        end
    end

    assign beep = beep_q;
    assign busy = (state_q == TONE);

endmodule
